// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, operand forwarding select,
// and a control-flow shadow that squashes decode after JAL/JALR/BRANCH.
//
// state  | meaning
// RUN    | normal issue; forwarding and load-use interlock active
// SHADOW | decode slot squashed (bubble=1) until cnt expires or resolve
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int PENALTY = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic              mm_valid,
  input  logic              mm_wr,
  input  logic              wb_valid,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mm_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              resolve,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd1,
  output logic [1:0]        fwd2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = (PENALTY < 1) ? 1 : $clog2(PENALTY + 1);
  localparam logic [PW-1:0] PEN = PW'(PENALTY);

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_hit1, mm_hit1, wb_hit1;
  logic ex_hit2, mm_hit2, wb_hit2;
  logic load_hazard;

  // Register 0 never hits, so it can never be forwarded or interlocked.
  assign ex_hit1 = ex_valid & ex_wr & (ex_rd == id_rs1) & (id_rs1 != '0);
  assign mm_hit1 = mm_valid & mm_wr & (mm_rd == id_rs1) & (id_rs1 != '0);
  assign wb_hit1 = wb_valid & wb_wr & (wb_rd == id_rs1) & (id_rs1 != '0);
  assign ex_hit2 = ex_valid & ex_wr & (ex_rd == id_rs2) & (id_rs2 != '0);
  assign mm_hit2 = mm_valid & mm_wr & (mm_rd == id_rs2) & (id_rs2 != '0);
  assign wb_hit2 = wb_valid & wb_wr & (wb_rd == id_rs2) & (id_rs2 != '0);

  // Load data is not ready in EX, so an EX load hit falls through to older stages.
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic ex_h,
                                         input logic mm_h, input logic wb_h,
                                         input logic is_load);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_rs) begin
      if (ex_h && !is_load) sel = 2'd1;
      else if (mm_h)        sel = 2'd2;
      else if (wb_h)        sel = 2'd3;
    end
    return sel;
  endfunction

  assign fwd1 = fwd_sel(id_use1, ex_hit1, mm_hit1, wb_hit1, ex_load);
  assign fwd2 = fwd_sel(id_use2, ex_hit2, mm_hit2, wb_hit2, ex_load);

  assign load_hazard = id_valid & ex_load &
                       ((id_use1 & ex_hit1) | (id_use2 & ex_hit2));
  assign stall  = load_hazard & (state_q != SHADOW);
  assign bubble = (state_q == SHADOW);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (id_valid && id_ctrl && !stall) begin
          state_d = SHADOW;
          cnt_d   = PEN;
        end
      end
      SHADOW: begin
        if (resolve || (cnt_q == PW'(1))) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if ((stall || bubble) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (PENALTY 2/4/3, the last with a
// 4-bit stall counter) share stimulus; expectations queue up and drain on sample.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_ctrl;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_valid, ex_wr, ex_load, mm_valid, mm_wr, wb_valid, wb_wr;
  logic [4:0] ex_rd, mm_rd, wb_rd;
  logic       resolve;

  logic        stall_a, bubble_a, stall_b, bubble_b, stall_c, bubble_c;
  logic [1:0]  fwd1_a, fwd2_a, fwd1_b, fwd2_b, fwd1_c, fwd2_c;
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;

  localparam int S_STALL_A = 0, S_BUB_A = 1, S_FWD1 = 2, S_FWD2 = 3, S_CNT_A = 4;
  localparam int S_BUB_B = 5, S_CNT_B = 6, S_BUB_C = 7, S_CNT_C = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .PENALTY(2), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_wr(ex_wr),
    .ex_load(ex_load), .mm_valid(mm_valid), .mm_wr(mm_wr), .wb_valid(wb_valid), .wb_wr(wb_wr),
    .ex_rd(ex_rd), .mm_rd(mm_rd), .wb_rd(wb_rd), .resolve(resolve), .stall(stall_a),
    .bubble(bubble_a), .fwd1(fwd1_a), .fwd2(fwd2_a), .stall_cnt(cnt_a));

  hazard_ctrl #(.REG_AW(5), .PENALTY(4), .CNT_W(32)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_wr(ex_wr),
    .ex_load(ex_load), .mm_valid(mm_valid), .mm_wr(mm_wr), .wb_valid(wb_valid), .wb_wr(wb_wr),
    .ex_rd(ex_rd), .mm_rd(mm_rd), .wb_rd(wb_rd), .resolve(resolve), .stall(stall_b),
    .bubble(bubble_b), .fwd1(fwd1_b), .fwd2(fwd2_b), .stall_cnt(cnt_b));

  hazard_ctrl #(.REG_AW(5), .PENALTY(3), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_valid(ex_valid), .ex_wr(ex_wr),
    .ex_load(ex_load), .mm_valid(mm_valid), .mm_wr(mm_wr), .wb_valid(wb_valid), .wb_wr(wb_wr),
    .ex_rd(ex_rd), .mm_rd(mm_rd), .wb_rd(wb_rd), .resolve(resolve), .stall(stall_c),
    .bubble(bubble_c), .fwd1(fwd1_c), .fwd2(fwd2_c), .stall_cnt(cnt_c));

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_STALL_A: return 32'(stall_a);
      S_BUB_A:   return 32'(bubble_a);
      S_FWD1:    return 32'(fwd1_a);
      S_FWD2:    return 32'(fwd2_a);
      S_CNT_A:   return cnt_a;
      S_BUB_B:   return 32'(bubble_b);
      S_CNT_B:   return cnt_b;
      S_BUB_C:   return 32'(bubble_c);
      S_CNT_C:   return 32'(cnt_c);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_ctrl = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_wr = 0; ex_load = 0; mm_valid = 0; mm_wr = 0;
    wb_valid = 0; wb_wr = 0; ex_rd = 0; mm_rd = 0; wb_rd = 0; resolve = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic ex_load_hit_rs1(input logic [4:0] r);
    ex_valid = 1; ex_wr = 1; ex_load = 1; ex_rd = r;
    id_valid = 1; id_use1 = 1; id_rs1 = r;
  endtask

  // Independent reference for forwarding: walk stages youngest to oldest.
  function automatic logic [1:0] m_fwd(input logic use_b, input logic [4:0] rs);
    logic       v[3];
    logic       w[3];
    logic [4:0] d[3];
    if (!use_b || rs == 5'd0) return 2'd0;
    v[0] = ex_valid && !ex_load; w[0] = ex_wr; d[0] = ex_rd;
    v[1] = mm_valid;             w[1] = mm_wr; d[1] = mm_rd;
    v[2] = wb_valid;             w[2] = wb_wr; d[2] = wb_rd;
    for (int k = 0; k < 3; k++)
      if (v[k] && w[k] && d[k] == rs) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    logic h1, h2;
    h1 = id_use1 && id_rs1 != 5'd0 && ex_rd == id_rs1;
    h2 = id_use2 && id_rs2 != 5'd0 && ex_rd == id_rs2;
    return id_valid && ex_valid && ex_wr && ex_load && (h1 || h2);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    expect_val("rst_bubble", S_BUB_A, 0);
    expect_val("rst_cnt", S_CNT_A, 0);
    expect_val("rst_stall", S_STALL_A, 0);
    expect_val("rst_fwd1", S_FWD1, 0);
    settle();

    // Load-use interlock, then forward from MM once the load advances
    ex_load_hit_rs1(5'd5);
    expect_val("lu_stall", S_STALL_A, 1);
    expect_val("lu_fwd1", S_FWD1, 0);
    settle();
    step();
    ex_valid = 0; ex_load = 0; mm_valid = 1; mm_wr = 1; mm_rd = 5'd5;
    expect_val("lu_stall_clr", S_STALL_A, 0);
    expect_val("lu_fwd1_mm", S_FWD1, 2);
    expect_val("lu_cnt", S_CNT_A, 1);
    settle();

    // Forwarding priority on rs2
    idle_inputs();
    id_valid = 1; id_use2 = 1; id_rs2 = 5'd7;
    ex_valid = 1; ex_wr = 1; ex_rd = 5'd7;
    mm_valid = 1; mm_wr = 1; mm_rd = 5'd7;
    wb_valid = 1; wb_wr = 1; wb_rd = 5'd7;
    expect_val("pri_ex", S_FWD2, 1);
    settle();
    ex_valid = 0;
    expect_val("pri_mm", S_FWD2, 2);
    settle();
    mm_valid = 0;
    expect_val("pri_wb", S_FWD2, 3);
    settle();
    id_use2 = 0;
    expect_val("pri_nouse", S_FWD2, 0);
    settle();
    id_use2 = 1; id_rs2 = 0; ex_rd = 0; mm_rd = 0; wb_rd = 0;
    ex_valid = 1; mm_valid = 1;
    expect_val("pri_x0", S_FWD2, 0);
    settle();
    id_rs2 = 5'd7; ex_rd = 5'd7; mm_rd = 5'd7; ex_load = 1;
    expect_val("pri_ldskip", S_FWD2, 2);
    expect_val("pri_ldstall", S_STALL_A, 1);
    settle();

    // Randomised forwarding / interlock against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      id_valid = 1'($urandom_range(0, 1)); id_use1 = 1'($urandom_range(0, 1));
      id_use2 = 1'($urandom_range(0, 1));  id_ctrl = 0;
      id_rs1 = 5'($urandom_range(0, 3));   id_rs2 = 5'($urandom_range(0, 3));
      ex_valid = 1'($urandom_range(0, 1)); ex_wr = 1'($urandom_range(0, 1));
      ex_load = 1'($urandom_range(0, 1));  ex_rd = 5'($urandom_range(0, 3));
      mm_valid = 1'($urandom_range(0, 1)); mm_wr = 1'($urandom_range(0, 1));
      mm_rd = 5'($urandom_range(0, 3));    wb_valid = 1'($urandom_range(0, 1));
      wb_wr = 1'($urandom_range(0, 1));    wb_rd = 5'($urandom_range(0, 3));
      expect_val("rnd_fwd1", S_FWD1, 32'(m_fwd(id_use1, id_rs1)));
      expect_val("rnd_fwd2", S_FWD2, 32'(m_fwd(id_use2, id_rs2)));
      expect_val("rnd_stall", S_STALL_A, 32'(m_stall()));
      settle();
    end

    // Control shadow without resolve: PENALTY 2 / 4 / 3
    do_reset();
    id_valid = 1; id_ctrl = 1;
    step();
    idle_inputs();
    expect_val("sh_a_t1", S_BUB_A, 1);
    expect_val("sh_b_t1", S_BUB_B, 1);
    expect_val("sh_c_t1", S_BUB_C, 1);
    settle();
    ex_load_hit_rs1(5'd9);
    expect_val("sh_nostall", S_STALL_A, 0);
    settle();
    idle_inputs();
    step();
    expect_val("sh_a_t2", S_BUB_A, 1);
    expect_val("sh_c_t2", S_BUB_C, 1);
    settle();
    step();
    expect_val("sh_a_t3", S_BUB_A, 0);
    expect_val("sh_a_cnt", S_CNT_A, 2);
    expect_val("sh_b_t3", S_BUB_B, 1);
    expect_val("sh_c_t3", S_BUB_C, 1);
    settle();
    step();
    expect_val("sh_b_t4", S_BUB_B, 1);
    expect_val("sh_c_t4", S_BUB_C, 0);
    expect_val("sh_c_cnt", S_CNT_C, 3);
    settle();
    step();
    expect_val("sh_b_t5", S_BUB_B, 0);
    expect_val("sh_b_cnt", S_CNT_B, 4);
    settle();

    // Early resolve; resolve seen while still in RUN has no effect
    do_reset();
    id_valid = 1; id_ctrl = 1; resolve = 1;
    step();
    idle_inputs();
    expect_val("rs_b_t1", S_BUB_B, 1);
    expect_val("rs_a_t1", S_BUB_A, 1);
    settle();
    resolve = 1;
    step();
    resolve = 0;
    expect_val("rs_b_t2", S_BUB_B, 0);
    expect_val("rs_a_t2", S_BUB_A, 0);
    expect_val("rs_b_cnt", S_CNT_B, 1);
    settle();

    // Stalled branch waits for the interlock to clear before shadowing
    do_reset();
    ex_load_hit_rs1(5'd5);
    id_ctrl = 1;
    expect_val("sb_stall0", S_STALL_A, 1);
    settle();
    step();
    expect_val("sb_bub0", S_BUB_A, 0);
    expect_val("sb_stall1", S_STALL_A, 1);
    settle();
    step();
    expect_val("sb_bub1", S_BUB_A, 0);
    settle();
    ex_valid = 0; ex_load = 0; mm_valid = 1; mm_wr = 1; mm_rd = 5'd5;
    expect_val("sb_clr", S_STALL_A, 0);
    expect_val("sb_fwd1", S_FWD1, 2);
    settle();
    step();
    idle_inputs();
    expect_val("sb_t1", S_BUB_A, 1);
    settle();
    step();
    expect_val("sb_t2", S_BUB_A, 1);
    settle();
    step();
    expect_val("sb_t3", S_BUB_A, 0);
    expect_val("sb_cnt", S_CNT_A, 4);
    settle();

    // Reset in the middle of a shadow
    do_reset();
    id_valid = 1; id_ctrl = 1;
    step();
    idle_inputs();
    reset = 1;
    expect_val("rm_c_t1", S_BUB_C, 1);
    settle();
    step();
    expect_val("rm_c_t2", S_BUB_C, 0);
    expect_val("rm_c_cnt", S_CNT_C, 0);
    settle();
    reset = 0;
    step();
    expect_val("rm_c_t3", S_BUB_C, 0);
    expect_val("rm_a_t3", S_BUB_A, 0);
    settle();

    // Counter saturation on the 4-bit instance
    do_reset();
    ex_load_hit_rs1(5'd3);
    repeat (20) step();
    idle_inputs();
    expect_val("sat_c", S_CNT_C, 15);
    expect_val("sat_a", S_CNT_A, 20);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
